// File: rtl/control_unit.sv
// control_unit: multi-cycle instruction sequencer.
//   Walks each instruction through FETCH / DECODE / EXEC / MEM / WB and
//   drives the memory, register-file, PC and flag strobes. It also counts
//   retired instructions.
//
// Optional feature: define CONTROL_UNIT_TRAP_EN to send illegal opcodes
//   (0xC-0xE) to a sticky TRAP state. When it is undefined, an illegal opcode
//   behaves as a NOP that does not retire.
//
// Ports:
//   clk      in   1  clock, rising edge
//   rst      in   1  asynchronous, active-low reset
//   opcode   in   4  current instruction opcode, stable after ir_en
//   cond     in   3  branch condition select
//   flags    in   5  processor status flags
//   mem_ack  in   1  memory completes the current request this cycle
//   mem_req  out  1  memory request
//   mem_we   out  1  memory write (STORE only)
//   ir_en    out  1  instruction register load
//   pc_en    out  1  PC update
//   pc_sel   out  1  0 = PC+1, 1 = target
//   rf_we    out  1  register file write
//   wb_sel   out  1  0 = ALU result, 1 = memory data
//   flags_en out  1  flag register update
//   alu_op   out  4  ALU operation (EXEC only, else 0)
//   halted   out  1  in HALT
//   trap     out  1  in TRAP
//   state    out  3  current state encoding
//   retired  out 16  retired-instruction counter (wraps)
module control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    input  logic [2:0]  cond,
    input  logic [4:0]  flags,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_en,
    output logic        pc_en,
    output logic        pc_sel,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        flags_en,
    output logic [3:0]  alu_op,
    output logic        halted,
    output logic        trap,
    output logic [2:0]  state,
    output logic [15:0] retired
);

    localparam int unsigned RET_W = 16;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    // Instruction kind captured in DECODE for use by MEM and WB
    typedef enum logic [1:0] {
        K_NONE  = 2'd0,
        K_ALU   = 2'd1,
        K_LOAD  = 2'd2,
        K_STORE = 2'd3
    } kind_t;

    state_t             cur;
    state_t             nxt;
    kind_t              kind;
    kind_t              kind_nxt;
    logic               retire;
    logic [RET_W-1:0]   ret_q;
    logic               cond_true;

    logic               mem_req_c;
    logic               mem_we_c;
    logic               ir_en_c;
    logic               pc_en_c;
    logic               pc_sel_c;
    logic               rf_we_c;
    logic               wb_sel_c;
    logic               flags_en_c;
    logic [3:0]         alu_op_c;

    // Branch condition: a flag bit for cond 0-4, always taken for 5-7
    always_comb begin
        cond_true = 1'b1;
        case (cond)
            3'd0:    cond_true = flags[0];
            3'd1:    cond_true = flags[1];
            3'd2:    cond_true = flags[2];
            3'd3:    cond_true = flags[3];
            3'd4:    cond_true = flags[4];
            default: cond_true = 1'b1;
        endcase
    end

    // Next-state, kind latch and strobe decode
    always_comb begin
        nxt        = cur;
        kind_nxt   = kind;
        retire     = 1'b0;
        mem_req_c  = 1'b0;
        mem_we_c   = 1'b0;
        ir_en_c    = 1'b0;
        pc_en_c    = 1'b0;
        pc_sel_c   = 1'b0;
        rf_we_c    = 1'b0;
        wb_sel_c   = 1'b0;
        flags_en_c = 1'b0;
        alu_op_c   = 4'd0;

        case (cur)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_ack) begin
                    ir_en_c = 1'b1;
                    pc_en_c = 1'b1;
                    nxt     = S_DECODE;
                end
            end

            S_DECODE: begin
                nxt      = S_FETCH;
                kind_nxt = K_NONE;
                case (opcode)
                    4'h0: retire = 1'b1;
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                        kind_nxt = K_ALU;
                        nxt      = S_EXEC;
                    end
                    4'h8: begin
                        kind_nxt = K_LOAD;
                        nxt      = S_MEM;
                    end
                    4'h9: begin
                        kind_nxt = K_STORE;
                        nxt      = S_MEM;
                    end
                    4'hA: begin
                        pc_en_c  = 1'b1;
                        pc_sel_c = 1'b1;
                        retire   = 1'b1;
                    end
                    4'hB: begin
                        pc_en_c  = cond_true;
                        pc_sel_c = cond_true;
                        retire   = 1'b1;
                    end
                    4'hF: begin
                        nxt    = S_HALT;
                        retire = 1'b1;
                    end
                    default: begin
`ifdef CONTROL_UNIT_TRAP_EN
                        nxt = S_TRAP;
`else
                        nxt = S_FETCH;
`endif
                    end
                endcase
            end

            S_EXEC: begin
                alu_op_c   = opcode;
                flags_en_c = 1'b1;
                nxt        = S_WB;
            end

            S_MEM: begin
                mem_req_c = 1'b1;
                mem_we_c  = (kind == K_STORE);
                if (mem_ack) begin
                    if (kind == K_STORE) begin
                        nxt    = S_FETCH;
                        retire = 1'b1;
                    end else begin
                        nxt = S_WB;
                    end
                end
            end

            S_WB: begin
                rf_we_c  = 1'b1;
                wb_sel_c = (kind == K_LOAD);
                retire   = 1'b1;
                nxt      = S_FETCH;
            end

            S_HALT: nxt = S_HALT;

            S_TRAP: begin
`ifdef CONTROL_UNIT_TRAP_EN
                nxt = S_TRAP;
`else
                nxt = S_FETCH;
`endif
            end

            default: nxt = S_FETCH;
        endcase
    end

    // State, kind and retired counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur   <= S_FETCH;
            kind  <= K_NONE;
            ret_q <= '0;
        end else begin
            cur  <= nxt;
            kind <= kind_nxt;
            if (retire) begin
                ret_q <= ret_q + RET_W'(1);
            end
        end
    end

    // Reset forces every control output low, independent of the clock
    assign mem_req  = rst & mem_req_c;
    assign mem_we   = rst & mem_we_c;
    assign ir_en    = rst & ir_en_c;
    assign pc_en    = rst & pc_en_c;
    assign pc_sel   = rst & pc_sel_c;
    assign rf_we    = rst & rf_we_c;
    assign wb_sel   = rst & wb_sel_c;
    assign flags_en = rst & flags_en_c;
    assign alu_op   = rst ? alu_op_c : 4'd0;
    assign halted   = rst & (cur == S_HALT);
`ifdef CONTROL_UNIT_TRAP_EN
    assign trap     = rst & (cur == S_TRAP);
`else
    assign trap     = 1'b0;
`endif
    assign state    = cur;
    assign retired  = ret_q;

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: random instruction streams with random memory
// wait states. Each instruction is expanded into its expected per-cycle
// trace by a transaction-level model, and the DUT is compared cycle by cycle.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  opcode = 4'd0;
    logic [2:0]  cond = 3'd0;
    logic [4:0]  flags = 5'd0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, ir_en, pc_en, pc_sel, rf_we, wb_sel, flags_en;
    logic [3:0]  alu_op;
    logic        halted, trap;
    logic [2:0]  state;
    logic [15:0] retired;

    control_unit dut (
        .clk(clk), .rst(rst), .opcode(opcode), .cond(cond), .flags(flags),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .ir_en(ir_en),
        .pc_en(pc_en), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
        .flags_en(flags_en), .alu_op(alu_op), .halted(halted), .trap(trap),
        .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    // One expected clock cycle: inputs to drive and outputs to expect
    typedef struct {
        logic [3:0]  opc;
        logic [2:0]  cnd;
        logic [4:0]  flg;
        logic        ack;
        logic [2:0]  st;
        logic [13:0] outs;
        logic [15:0] ret;
    } cyc_t;

    cyc_t        q[$];
    int          n_err = 0;
    int          n_chk = 0;
    logic [15:0] model_ret = 16'd0;
    logic [3:0]  prev_op = 4'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output vector order: req we ir pce pcs rfwe wbs fen aop[3:0] hlt trp
    function automatic logic [13:0] pk(input logic req, input logic we, input logic ir,
                                       input logic pce, input logic pcs, input logic rfwe,
                                       input logic wbs, input logic fen, input logic [3:0] aop,
                                       input logic hlt, input logic trp);
        return {req, we, ir, pce, pcs, rfwe, wbs, fen, aop, hlt, trp};
    endfunction

    function automatic logic [13:0] dut_outs();
        return {mem_req, mem_we, ir_en, pc_en, pc_sel, rf_we, wb_sel, flags_en,
                alu_op, halted, trap};
    endfunction

    task automatic push(input logic [3:0] opc, input logic [2:0] cnd, input logic [4:0] flg,
                        input logic ack, input logic [2:0] st, input logic [13:0] outs);
        cyc_t c;
        c.opc = opc; c.cnd = cnd; c.flg = flg; c.ack = ack;
        c.st = st; c.outs = outs; c.ret = model_ret;
        q.push_back(c);
    endtask

    // Expected trace of one instruction: wf fetch waits, wm memory waits
    task automatic gen_instr(input logic [3:0] op, input logic [2:0] c, input logic [4:0] f,
                             input int wf, input int wm);
        logic taken;
        for (int i = 0; i < wf; i++)
            push(prev_op, 3'($urandom), 5'($urandom), 1'b0, 3'd0, pk(1,0,0,0,0,0,0,0,4'd0,0,0));
        push(prev_op, 3'($urandom), 5'($urandom), 1'b1, 3'd0, pk(1,0,1,1,0,0,0,0,4'd0,0,0));
        prev_op = op;
        if (op == 4'h0 || op == 4'hF) begin
            push(op, c, f, 1'($urandom), 3'd1, '0);
            model_ret++;
        end else if (op <= 4'h7) begin
            push(op, c, f, 1'($urandom), 3'd1, '0);
            push(op, 3'($urandom), 5'($urandom), 1'($urandom), 3'd2, pk(0,0,0,0,0,0,0,1,op,0,0));
            push(op, 3'($urandom), 5'($urandom), 1'($urandom), 3'd4, pk(0,0,0,0,0,1,0,0,4'd0,0,0));
            model_ret++;
        end else if (op == 4'h8 || op == 4'h9) begin
            push(op, c, f, 1'($urandom), 3'd1, '0);
            for (int i = 0; i <= wm; i++)
                push(op, 3'($urandom), 5'($urandom), (i == wm), 3'd3,
                     pk(1, op == 4'h9, 0,0,0,0,0,0,4'd0,0,0));
            if (op == 4'h8)
                push(op, 3'($urandom), 5'($urandom), 1'($urandom), 3'd4, pk(0,0,0,0,0,1,1,0,4'd0,0,0));
            model_ret++;
        end else if (op == 4'hA) begin
            push(op, c, f, 1'($urandom), 3'd1, pk(0,0,0,1,1,0,0,0,4'd0,0,0));
            model_ret++;
        end else if (op == 4'hB) begin
            if (c >= 3'd5) taken = 1'b1;
            else           taken = f[c];
            push(op, c, f, 1'($urandom), 3'd1, pk(0,0,0,taken,taken,0,0,0,4'd0,0,0));
            model_ret++;
        end else begin
            push(op, c, f, 1'($urandom), 3'd1, '0);
        end
    endtask

    task automatic gen_idle(input logic [2:0] st, input int n);
        for (int i = 0; i < n; i++)
            push(prev_op, 3'($urandom), 5'($urandom), 1'($urandom), st,
                 pk(0,0,0,0,0,0,0,0,4'd0, st == 3'd5, st == 3'd6));
    endtask

    // Each cycle starts just after a rising edge; outputs sampled on the falling edge
    task automatic run_n(input int n);
        cyc_t c;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            c = q.pop_front();
            opcode = c.opc; cond = c.cnd; flags = c.flg; mem_ack = c.ack;
            @(negedge clk);
            check("state", 32'(state), 32'(c.st));
            check("retired", 32'(retired), 32'(c.ret));
            check("outs", 32'(dut_outs()), 32'(c.outs));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_all();
        run_n(q.size());
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        q.delete();
        for (int i = 0; i < n; i++) begin
            mem_ack = 1'($urandom);
            @(negedge clk);
            check("rst_state", 32'(state), 32'd0);
            check("rst_retired", 32'(retired), 32'd0);
            check("rst_outs", 32'(dut_outs()), 32'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        model_ret = 16'd0;
    endtask

    logic [3:0] op;
    int         r;

    initial begin
        // Reset held across several clock edges
        #1;
        do_reset(3);

        // NOP then ALU op 3, zero-wait memory
        gen_instr(4'h0, 3'd0, 5'd0, 0, 0);
        gen_instr(4'h3, 3'd0, 5'd0, 0, 0);
        run_all();

        // LOAD with three wait cycles in both FETCH and MEM
        gen_instr(4'h8, 3'd0, 5'd0, 3, 3);
        run_all();

        // BRC cond=2, taken then not taken
        gen_instr(4'hB, 3'd2, 5'b00100, 0, 0);
        gen_instr(4'hB, 3'd2, 5'b00000, 0, 0);
        run_all();

        // Random instruction stream
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 13);
            if (r <= 11) op = 4'(r);
`ifdef CONTROL_UNIT_TRAP_EN
            else op = 4'h0;
`else
            else op = 4'($urandom_range(12, 14));
`endif
            gen_instr(op, 3'($urandom), 5'($urandom),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
            run_all();
        end

        // Illegal opcode 0xC
        gen_instr(4'hC, 3'd0, 5'd0, 0, 0);
`ifdef CONTROL_UNIT_TRAP_EN
        gen_idle(3'd6, 5);
        run_all();
        do_reset(1);
`else
        gen_instr(4'h0, 3'd0, 5'd0, 0, 0);
        run_all();
`endif

        // Asynchronous reset in the middle of a STORE memory wait
        gen_instr(4'h9, 3'd0, 5'd0, 0, 4);
        run_n(3);
        q.delete();
        mem_ack = 1'b0;
        #1;
        check("pre_rst_state", 32'(state), 32'd3);
        check("pre_rst_we", 32'(mem_we), 32'd1);
        rst = 1'b0;
        #1;
        check("async_state", 32'(state), 32'd0);
        check("async_req", 32'(mem_req), 32'd0);
        check("async_retired", 32'(retired), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_ret = 16'd0;
        #1;
        check("release_req", 32'(mem_req), 32'd1);
        check("release_state", 32'(state), 32'd0);
        gen_instr(4'h9, 3'd0, 5'd0, 2, 1);
        run_all();

        // Long NOP run, then HALT with no further requests
        for (int i = 0; i < 300; i++) gen_instr(4'h0, 3'd0, 5'd0, 0, 0);
        gen_instr(4'hF, 3'd0, 5'd0, 1, 0);
        gen_idle(3'd5, 8);
        run_all();
        check("halt_retired", 32'(retired), 32'd302);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port opcode  input  4  current instruction opcode, stable from the cycle after ir_en until the next ir_en.
REQ-004 SHALL have port cond  input  3  branch condition select.
REQ-005 SHALL have port flags  input  5  processor status flags (RFlags).
REQ-006 SHALL have port mem_ack  input  1  memory completes the current request this cycle.
REQ-007 SHALL have outputs mem_req (1), mem_we (1), ir_en (1), pc_en (1), pc_sel (1: 0 = PC+1, 1 = target), rf_we (1), wb_sel (1: 0 = ALU, 1 = memory), flags_en (1), alu_op (4), halted (1), trap (1), state (3), retired (16).

Function
REQ-008 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6; state output SHALL equal the current encoding; code 7 is unreachable and SHALL recover to FETCH on the next edge.
REQ-009 Opcode map SHALL be: 0 NOP; 1-7 ALU; 8 LOAD; 9 STORE; A JMP; B BRC; F HALT; C-E illegal.
REQ-010 FETCH SHALL assert mem_req=1, mem_we=0, and wait any number of cycles for mem_ack; in the ack cycle it SHALL pulse ir_en=1, pc_en=1, pc_sel=0, then go to DECODE.
REQ-011 DECODE SHALL last exactly one cycle, with these transitions:
- NOP: go to FETCH.
- ALU: go to EXEC.
- LOAD or STORE: go to MEM.
- JMP: pc_en=1, pc_sel=1, go to FETCH.
- BRC: pc_en=1, pc_sel=1 only if the condition is true; go to FETCH.
- HALT: go to HALT.
- Illegal: see REQ-021.
REQ-012 BRC condition SHALL be flags[cond] for cond 0-4; cond 5-7 SHALL always be true.
REQ-013 EXEC SHALL drive alu_op=opcode and flags_en=1 for one cycle, then go to WB; alu_op SHALL be 0 in every other state.
REQ-014 MEM SHALL assert mem_req=1 and mem_we=1 only for STORE, until mem_ack; on ack, LOAD goes to WB and STORE goes to FETCH.
REQ-015 WB SHALL assert rf_we=1 for one cycle, then go to FETCH; wb_sel SHALL be 1 if the instruction is LOAD, else 0. The LOAD/ALU kind SHALL be latched in DECODE.
REQ-016 HALT SHALL hold halted=1 with all strobes 0 until reset.
REQ-017 retired SHALL increment by 1, wrapping 0xFFFF to 0x0000, on the final cycle of each instruction:
- DECODE exit to FETCH.
- WB.
- MEM-STORE ack.
- DECODE exit to HALT.
Illegal opcodes SHALL NOT count.
REQ-018 Strobes (mem_req, ir_en, pc_en, rf_we, flags_en) SHALL be combinational from state, latched kind, opcode, cond, flags and mem_ack; they SHALL be 0 wherever not stated.
REQ-019 Minimum latencies SHALL be, with zero-wait memory:
- NOP, JMP, BRC: 2 cycles.
- ALU: 4 cycles.
- STORE: 3 cycles.
- LOAD: 4 cycles.

Reset
REQ-020 While rst=0, regardless of clk:
- state SHALL be FETCH, retired=0, and the latched kind cleared.
- All outputs except state and retired SHALL be forced to 0, including mem_req.
- First FETCH request SHALL appear in the cycle after rst rises.
Reset mid-request SHALL abandon the request with no ack pending.

Configuration
REQ-021 Macro CONTROL_UNIT_TRAP_EN:
- Defined: an illegal opcode in DECODE SHALL go to TRAP, which holds trap=1 with all strobes 0 until reset.
- Undefined: an illegal opcode SHALL behave as NOP without incrementing retired, trap SHALL be constant 0, and TRAP SHALL be unreachable.

Verification
REQ-022 Sequence NOP, then ALU op 3, with mem_ack=1 always -> state 0,1,0,1,2,4,0. alu_op=3 and flags_en=1 only in EXEC, rf_we only in WB, retired=2.
REQ-023 LOAD with mem_ack delayed 3 cycles in both FETCH and MEM -> mem_req held 4 cycles in each. wb_sel=1 and rf_we=1 in WB. mem_we=0 throughout.
REQ-024 BRC cond=2 with flags=5'b00100, then with flags=5'b00000 -> first case pc_en=1, pc_sel=1 in DECODE. Second case pc_en=0 in DECODE. Both return to FETCH.
REQ-025 rst pulsed low mid-MEM of a STORE -> immediately state=0, mem_req=0, retired=0. Next FETCH request appears one cycle after release.
REQ-026 Opcode 0xC, with and without CONTROL_UNIT_TRAP_EN -> with it, state=6, trap=1, stuck until reset. Without it, state returns to 0 and retired unchanged.
REQ-027 65536 NOPs -> retired wraps to 0x0000. HALT afterwards -> halted=1, retired=1, no further mem_req.
